scoreboard_register_file: RTL and testbench

//  Parametrised MIPS GPR file: NREAD async read ports, one sync write (writeback) port.

---
 rtl/scoreboard_register_file_pkg.sv | 18 +
 rtl/scoreboard_register_file_if.sv | 35 +++
 rtl/scoreboard_register_file_scoreboard.sv | 64 ++++++
 rtl/scoreboard_register_file.sv | 78 +++++++
 tb/tb_scoreboard_register_file.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_register_file_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizes and types for the scoreboarded register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
  localparam int WIDTH   = 32;
  localparam int REGSIZE = 5;
  localparam int NREGS   = 1 << REGSIZE;

  typedef logic [REGSIZE-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]   reg_data_t;
  typedef logic [REGSIZE:0]   pend_cnt_t;
endpackage

`default_nettype wire

// File: rtl/scoreboard_register_file_if.sv
// ============================================================================
// Module   : scoreboard_register_file_if
// Purpose  : Decode/issue/writeback bundle seen by the scoreboarded register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scoreboard_register_file_if
  import regfile_pkg::*;
#(
  parameter int NREAD = 2
);
  logic [NREAD*REGSIZE-1:0] readAddress;
  logic [NREAD*WIDTH-1:0]   readValue;
  logic [NREAD-1:0]         readReady;
  logic                     issueEnable;
  reg_addr_t                issueAddress;
  logic                     issueAccept;
  logic                     writeEnable;
  reg_addr_t                writeAddress;
  reg_data_t                writeValue;
  pend_cnt_t                pendingCount;

  modport master (
    output readAddress, issueEnable, issueAddress, writeEnable, writeAddress, writeValue,
    input  readValue, readReady, issueAccept, pendingCount
  );

  modport slave (
    input  readAddress, issueEnable, issueAddress, writeEnable, writeAddress, writeValue,
    output readValue, readReady, issueAccept, pendingCount
  );
endinterface

`default_nettype wire

// File: rtl/scoreboard_register_file_scoreboard.sv
// ============================================================================
// Module   : reg_busy_scoreboard
// Purpose  : Per-register busy bits, pending counter and issue grant logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_busy_scoreboard
  import regfile_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       issue_en_i,
  input  wire reg_addr_t  issue_addr_i,
  input  wire logic       wr_en_i,
  input  wire reg_addr_t  wr_addr_i,
  output logic            issue_accept_o,
  output logic [NREGS-1:0] busy_o,
  output pend_cnt_t       pending_count_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  pend_cnt_t        count_q, count_d;
  logic             w_same_reg;
  logic             w_set;
  logic             w_clr;
  logic             w_inc;
  logic             w_dec;

  always_comb begin
    w_same_reg     = wr_en_i & (wr_addr_i == issue_addr_i);
    issue_accept_o = issue_en_i & ((issue_addr_i == '0) | ~busy_q[issue_addr_i] | w_same_reg);
    w_set          = issue_accept_o & (issue_addr_i != '0);
    w_clr          = wr_en_i & (wr_addr_i != '0);
    w_inc          = w_set & ~busy_q[issue_addr_i];
    // A writeback racing a new issue to the same register hands it to the new producer.
    w_dec          = w_clr & busy_q[wr_addr_i] & ~(w_set & (wr_addr_i == issue_addr_i));

    busy_d = busy_q;
    if (w_clr) busy_d[wr_addr_i] = 1'b0;
    if (w_set) busy_d[issue_addr_i] = 1'b1;
    busy_d[0] = 1'b0;

    count_d = count_q;
    if (w_inc && !w_dec)      count_d = count_q + pend_cnt_t'(1);
    else if (w_dec && !w_inc) count_d = count_q - pend_cnt_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o          = busy_q;
  assign pending_count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/scoreboard_register_file.sv
// ============================================================================
// Module   : scoreboard_register_file
// Purpose  : MIPS GPR file with async reads, one writeback port and busy scoreboard.
//            Optional write-to-read forwarding: SCOREBOARD_REGISTER_FILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int NREAD = 2
)(
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  scoreboard_register_file_if.slave    rf_bus
);

  reg_data_t        regs_q [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_wr_valid;

  assign w_wr_valid = rf_bus.writeEnable & (rf_bus.writeAddress != '0);

  reg_busy_scoreboard u_scoreboard (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_en_i      (rf_bus.issueEnable),
    .issue_addr_i    (rf_bus.issueAddress),
    .wr_en_i         (rf_bus.writeEnable),
    .wr_addr_i       (rf_bus.writeAddress),
    .issue_accept_o  (rf_bus.issueAccept),
    .busy_o          (w_busy),
    .pending_count_o (rf_bus.pendingCount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else if (w_wr_valid) begin
      regs_q[rf_bus.writeAddress] <= rf_bus.writeValue;
    end
  end

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
      reg_addr_t w_addr;
      reg_data_t w_value;
      logic      w_ready;
      logic      w_fwd;

      assign w_addr = rf_bus.readAddress[gi*REGSIZE +: REGSIZE];
`ifdef SCOREBOARD_REGISTER_FILE_BYPASS_EN
      assign w_fwd = w_wr_valid & (rf_bus.writeAddress == w_addr);
`else
      assign w_fwd = 1'b0;
`endif

      always_comb begin
        w_value = regs_q[w_addr];
        w_ready = ~w_busy[w_addr];
        if (w_addr == '0) begin
          w_value = '0;
          w_ready = 1'b1;
        end else if (w_fwd) begin
          w_value = rf_bus.writeValue;
          w_ready = 1'b1;
        end
      end

      assign rf_bus.readValue[gi*WIDTH +: WIDTH] = w_value;
      assign rf_bus.readReady[gi]                = w_ready;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
// ============================================================================
// Module   : tb_scoreboard_register_file
// Purpose  : Scoreboard bench: directed scenarios plus random traffic vs a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scoreboard_register_file;
  import regfile_pkg::*;

  typedef struct {
    string     tag;
    reg_data_t rv0;
    reg_data_t rv1;
    logic [1:0] rr;
    logic      acc;
    pend_cnt_t cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  reg_data_t m_mem  [NREGS];
  bit        m_busy [NREGS];

  scoreboard_register_file_if #(.NREAD(2)) rf_bus ();

  scoreboard_register_file #(.NREAD(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rf_bus (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_pending();
    int n = 0;
    for (int k = 0; k < NREGS; k++) n += m_busy[k] ? 1 : 0;
    return n;
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < NREGS; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
  endfunction

  function automatic void m_read(input reg_addr_t a, input logic we, input reg_addr_t wa,
                                 input reg_data_t wv, output reg_data_t v, output logic r);
    if (a == 0) begin
      v = '0; r = 1'b1;
    end else begin
      v = m_mem[a]; r = !m_busy[a];
`ifdef SCOREBOARD_REGISTER_FILE_BYPASS_EN
      if (we && wa == a) begin v = wv; r = 1'b1; end
`endif
    end
  endfunction

  // One cycle of stimulus: drive at posedge+1, queue expectation, advance model at edge.
  task automatic cycle(input string tag, input logic rst, input logic ie, input reg_addr_t ia,
                       input logic we, input reg_addr_t wa, input reg_data_t wv,
                       input reg_addr_t ra0, input reg_addr_t ra1);
    exp_t e;
    logic acc;
    rst_n                = !rst;
    rf_bus.issueEnable   = ie;
    rf_bus.issueAddress  = ia;
    rf_bus.writeEnable   = we;
    rf_bus.writeAddress  = wa;
    rf_bus.writeValue    = wv;
    rf_bus.readAddress   = {ra1, ra0};
    if (rst) m_clear();
    acc = ie && (ia == 0 || !m_busy[ia] || (we && wa == ia));
    e.tag = tag;
    m_read(ra0, we, wa, wv, e.rv0, e.rr[0]);
    m_read(ra1, we, wa, wv, e.rv1, e.rr[1]);
    e.acc = acc;
    e.cnt = pend_cnt_t'(m_pending());
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (we && wa != 0) begin
        m_mem[wa]  = wv;
        m_busy[wa] = 1'b0;
      end
      if (acc && ia != 0) m_busy[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "rv0", rf_bus.readValue[31:0],  e.rv0);
        chk(e.tag, "rv1", rf_bus.readValue[63:32], e.rv1);
        chk(e.tag, "ready", 32'(rf_bus.readReady), 32'(e.rr));
        chk(e.tag, "accept", 32'(rf_bus.issueAccept), 32'(e.acc));
        chk(e.tag, "pending", 32'(rf_bus.pendingCount), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reg_addr_t ia, wa, r0, r1;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rf_bus.issueEnable  = 1'b0;
    rf_bus.issueAddress = '0;
    rf_bus.writeEnable  = 1'b0;
    rf_bus.writeAddress = '0;
    rf_bus.writeValue   = '0;
    rf_bus.readAddress  = '0;
    m_clear();
    @(posedge clk); #1;

    cycle("reset",    1, 0, 0, 0, 0, 0, 5, 7);
    cycle("wr_r5",    0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    cycle("wr_r0",    0, 0, 0, 1, 0, 32'h1234, 5, 0);
    cycle("rd_r0",    0, 0, 0, 0, 0, 0, 0, 5);
    cycle("wr_r6",    0, 0, 0, 1, 6, 32'hCAFE0006, 6, 5);
    cycle("rst_mid",  1, 0, 0, 0, 0, 0, 5, 6);
    cycle("rst_rel",  0, 0, 0, 0, 0, 0, 5, 6);

    cycle("iss_r7",   0, 1, 7, 0, 0, 0, 7, 0);
    cycle("reiss_r7", 0, 1, 7, 0, 0, 0, 7, 0);
    cycle("wb_r7",    0, 0, 0, 1, 7, 32'h55, 7, 0);
    cycle("rd_r7",    0, 1, 0, 0, 0, 0, 7, 0);

    cycle("iss_r9",   0, 1, 9, 0, 0, 0, 9, 0);
    cycle("wbiss_r9", 0, 1, 9, 1, 9, 32'hA0, 9, 0);
    cycle("rd_r9",    0, 0, 0, 0, 0, 0, 9, 0);
    cycle("wb_r9",    0, 0, 0, 1, 9, 32'hA1, 9, 0);

    cycle("wr_r3",    0, 0, 0, 1, 3, 32'h11, 0, 3);
    cycle("byp_r3",   0, 0, 0, 1, 3, 32'h77, 3, 3);
    cycle("rd_r3",    0, 0, 0, 0, 0, 0, 3, 3);

    for (int k = 1; k < NREGS; k++)
      cycle("iss_all", 0, 1, reg_addr_t'(k), 0, 0, 0, reg_addr_t'(k), 0);
    cycle("full",     0, 1, 12, 0, 0, 0, 31, 1);
    cycle("full_rst", 1, 1, 12, 0, 0, 0, 31, 1);
    cycle("after",    0, 0, 0, 0, 0, 0, 31, 1);

    for (int n = 0; n < 500; n++) begin
      ia = ($urandom_range(0, 3) == 0) ? reg_addr_t'($urandom) : reg_addr_t'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) == 0) ? reg_addr_t'($urandom) : reg_addr_t'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 1) == 0) ? wa : reg_addr_t'($urandom_range(0, 9));
      r1 = ($urandom_range(0, 1) == 0) ? ia : reg_addr_t'($urandom);
      cycle("random", ($urandom_range(0, 79) == 0), 1'($urandom), ia,
            1'($urandom), wa, reg_data_t'($urandom), r0, r1);
    end
    cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
